// File: rtl/mesh_boot_pkg.sv
// Shared types and header field layout for the mesh boot sequencer.
// A header word carries {proc_id, icount, dcount}; proc_id 4'hF ends the stream.
package mesh_boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_IMEM = 3'd2,
      ST_DMEM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } boot_state_t;

   localparam int PID_MSB  = 31;
   localparam int PID_LSB  = 28;
   localparam int ICNT_MSB = 27;
   localparam int ICNT_LSB = 14;
   localparam int DCNT_MSB = 13;
   localparam int DCNT_LSB = 0;

   localparam logic [3:0] END_PID = 4'hF;

   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mesh_boot_sequencer_counter.sv
// Boot word counter shared by the instruction and data phases.
// Flags the last word of the current image by comparing against target-1.
module boot_word_counter #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              clear,
   input  logic              inc,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] count,
   output logic              last
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + ONE;
      end
   end

   assign last = (count == (target - ONE));

endmodule

// File: rtl/mesh_boot_sequencer.sv
// Boots the processor mesh from one host word stream: decodes image headers,
// writes instruction/data words to the selected processor, then releases reset.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | one cycle after reset release, no host words accepted
// HDR   | waiting for an image header or the END marker
// IMEM  | streaming icount instruction words to proc_id
// DMEM  | streaming dcount data words to proc_id
// DONE  | all images loaded, mesh released from reset (until reset)
// ERR   | illegal proc_id seen, mesh held in reset (until reset)
module mesh_boot_sequencer
   import mesh_boot_pkg::*;
#(
   parameter int NUM_PROCS = 9,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 host_valid,
   input  logic [DATA_W-1:0]    host_data,
   output logic                 host_ready,
   output logic [ADDR_W-1:0]    boot_iaddr,
   output logic [DATA_W-1:0]    boot_idata,
   output logic [NUM_PROCS-1:0] boot_iwe,
   output logic [ADDR_W-1:0]    boot_daddr,
   output logic [DATA_W-1:0]    boot_ddata,
   output logic [NUM_PROCS-1:0] boot_dwe,
   output logic                 procs_resetn,
   output logic                 boot_done,
   output logic                 boot_error
);

   localparam logic [3:0] NUM_PROCS_L = 4'(NUM_PROCS);

   boot_state_t state, state_nxt;

   logic              accept;
   logic [3:0]        hdr_pid;
   logic [ADDR_W-1:0] hdr_icnt;
   logic [ADDR_W-1:0] hdr_dcnt;
   logic              hdr_load;

   logic [3:0]        pid_q;
   logic [ADDR_W-1:0] icnt_q;
   logic [ADDR_W-1:0] dcnt_q;

   logic              wr_i;
   logic              wr_d;
   logic              cnt_clear;
   logic              cnt_inc;
   logic [ADDR_W-1:0] cnt_target;
   logic [ADDR_W-1:0] cnt;
   logic              cnt_last;
   logic [NUM_PROCS-1:0] pid_onehot;

   assign host_ready = (state == ST_HDR) || (state == ST_IMEM) || (state == ST_DMEM);
   assign accept     = host_valid && host_ready;

   assign hdr_pid  = host_data[PID_MSB:PID_LSB];
   assign hdr_icnt = host_data[ICNT_MSB:ICNT_LSB];
   assign hdr_dcnt = host_data[DCNT_MSB:DCNT_LSB];

   assign hdr_load = (state == ST_HDR) && accept
                     && (hdr_pid != END_PID) && (hdr_pid < NUM_PROCS_L);

   assign wr_i = accept && (state == ST_IMEM);
   assign wr_d = accept && (state == ST_DMEM);

   // One counter serves both phases; it is cleared at the IMEM->DMEM hand-over.
   assign cnt_target = (state == ST_DMEM) ? dcnt_q : icnt_q;
   assign cnt_clear  = hdr_load || ((wr_i || wr_d) && cnt_last);
   assign cnt_inc    = (wr_i || wr_d) && !cnt_last;
   assign pid_onehot = NUM_PROCS'(1) << pid_q;

   boot_word_counter #(
      .ADDR_W (ADDR_W)
   ) u_counter (
      .clk    (clk),
      .resetn (resetn),
      .clear  (cnt_clear),
      .inc    (cnt_inc),
      .target (cnt_target),
      .count  (cnt),
      .last   (cnt_last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = ST_HDR;
         ST_HDR: begin
            if (accept) begin
               if (hdr_pid == END_PID) begin
                  state_nxt = ST_DONE;
               end else if (hdr_pid >= NUM_PROCS_L) begin
                  state_nxt = ST_ERR;
               end else if (hdr_icnt != '0) begin
                  state_nxt = ST_IMEM;
               end else if (hdr_dcnt != '0) begin
                  state_nxt = ST_DMEM;
               end else begin
                  state_nxt = ST_HDR;
               end
            end
         end
         ST_IMEM: begin
            if (accept && cnt_last) begin
               state_nxt = (dcnt_q != '0) ? ST_DMEM : ST_HDR;
            end
         end
         ST_DMEM: begin
            if (accept && cnt_last) begin
               state_nxt = ST_HDR;
            end
         end
         ST_DONE: state_nxt = ST_DONE;
         ST_ERR:  state_nxt = ST_ERR;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pid_q  <= '0;
         icnt_q <= '0;
         dcnt_q <= '0;
      end else if (hdr_load) begin
         pid_q  <= hdr_pid;
         icnt_q <= hdr_icnt;
         dcnt_q <= hdr_dcnt;
      end
   end

   // Address/data hold their last value between pulses; only the enables drop.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         boot_iaddr   <= '0;
         boot_idata   <= '0;
         boot_iwe     <= '0;
         boot_daddr   <= '0;
         boot_ddata   <= '0;
         boot_dwe     <= '0;
         procs_resetn <= 1'b0;
         boot_done    <= 1'b0;
         boot_error   <= 1'b0;
      end else begin
         boot_iwe <= wr_i ? pid_onehot : '0;
         boot_dwe <= wr_d ? pid_onehot : '0;
         if (wr_i) begin
            boot_iaddr <= cnt;
            boot_idata <= host_data;
         end
         if (wr_d) begin
            boot_daddr <= cnt;
            boot_ddata <= host_data;
         end
         procs_resetn <= (state_nxt == ST_DONE);
         boot_done    <= (state_nxt == ST_DONE);
         boot_error   <= (state_nxt == ST_ERR);
      end
   end

endmodule
